// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared states, digit width and sizing helpers for the BCD converter
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int DIGIT_W = 4;
  function automatic int int_digits(input int bin_w);
    return (bin_w + 2) / 3;
  endfunction
  function automatic longint max_dec(input int digits);
    longint r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: adds 3 to a BCD digit of 5 or more so the following left shift carries correctly
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 converter, one bit per clock; BIN2BCD_SAT_EN clamps out-of-range values to all nines
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);
  localparam int ND = int_digits(BIN_W);
  localparam int DW = DIGIT_W * ND;
  localparam int OW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  state_e          state_q;
  logic [DW-1:0]   dig_q, corr, dig_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [OW-1:0]   bcd_q, out_w;
`ifdef BIN2BCD_SAT_EN
  localparam logic [63:0] MAXV = 64'(max_dec(DIGITS));
  logic sat_q;
`endif
  for (genvar g = 0; g < ND; g++) begin : g_add
    bcd_add3 u_add (.d_i(dig_q[DIGIT_W*g +: DIGIT_W]), .d_o(corr[DIGIT_W*g +: DIGIT_W]));
  end
  // digits beyond the internal field read as zero; internal digits above DIGITS are dropped
  for (genvar d = 0; d < DIGITS; d++) begin : g_out
    if (d < ND) begin : g_dig
      assign out_w[DIGIT_W*d +: DIGIT_W] = dig_q[DIGIT_W*d +: DIGIT_W];
    end else begin : g_zero
      assign out_w[DIGIT_W*d +: DIGIT_W] = '0;
    end
  end
  assign dig_d = (corr << 1) | DW'(sh_q[BIN_W-1]);
  assign sh_d  = sh_q << 1;
  // conversion FSM: capture on start, BIN_W correct-and-shift steps, then publish the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sh_q    <= bin;
          dig_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
`ifdef BIN2BCD_SAT_EN
          sat_q   <= 64'(bin) > MAXV;
`endif
        end
        SHIFT: begin
          dig_q <= dig_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_q <= DONE;
        end
        default: begin
`ifdef BIN2BCD_SAT_EN
          bcd_q <= sat_q ? {DIGITS{4'h9}} : out_w;
`else
          bcd_q <= out_w;
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule
